// File: rtl/vera_video_pkg.sv
// Shared timing definitions for the VERA demo raster generator.
package vera_video_pkg;

    // One axis of raster timing, all values in pixels (horizontal) or lines (vertical).
    typedef struct packed {
        logic [9:0] active;
        logic [9:0] fp;
        logic [9:0] sync;
        logic [9:0] bp;
    } timing_t;

    localparam timing_t T_H = '{active: 10'd640, fp: 10'd16, sync: 10'd96, bp: 10'd48};
    localparam timing_t T31 = '{active: 10'd480, fp: 10'd10, sync: 10'd2,  bp: 10'd33};
    localparam timing_t T15 = '{active: 10'd240, fp: 10'd4,  sync: 10'd3,  bp: 10'd15};

    // Sync/blank idle pattern {HB,HS,VB,VS}: blanked, no sync.
    localparam logic [3:0] SB_IDLE = 4'b1010;

    // Full period of one axis; kept 12 bits wide so oversized settings stay detectable.
    function automatic logic [11:0] total(input timing_t t);
        return {2'b00, t.active} + {2'b00, t.fp} + {2'b00, t.sync} + {2'b00, t.bp};
    endfunction

    // First position after the sync pulse (exclusive end of sync).
    function automatic logic [11:0] sync_end(input timing_t t);
        return {2'b00, t.active} + {2'b00, t.fp} + {2'b00, t.sync};
    endfunction

    localparam logic [11:0] H_TOTAL = total(T_H);

endpackage

// File: rtl/vera_sync_delay.sv
// Enable-qualified shift register used to align sync/blank with downstream pipelines.
module vera_sync_delay #(
    parameter int               WIDTH   = 4,
    parameter int               DEPTH   = 3,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    logic [WIDTH-1:0] stage_q [DEPTH];
    logic [WIDTH-1:0] stage_d [DEPTH];

    // Next-state: shift one stage per enable, otherwise hold.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            stage_d[i] = stage_q[i];
        end
        if (en) begin
            stage_d[0] = din;
            for (int i = 1; i < DEPTH; i++) begin
                stage_d[i] = stage_q[i-1];
            end
        end else begin
            stage_d[0] = stage_q[0];
        end
    end

    // Stage registers; reset fills every stage with the idle pattern.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                stage_q[i] <= RST_VAL;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                stage_q[i] <= stage_d[i];
            end
        end
    end

    assign dout = stage_q[DEPTH-1];

endmodule

// File: rtl/vera_video_timing.sv
// Raster timing generator: pixel enable, counters, fetch window and
// pipeline-aligned sync/blank for the VERA composer (31 kHz / 15 kHz).
module vera_video_timing
    import vera_video_pkg::*;
#(
    parameter int      CE_DIV   = 2,
    parameter int      PIPE_DLY = 3,
    parameter timing_t H_TIM    = T_H,
    parameter timing_t V31_TIM  = T31,
    parameter timing_t V15_TIM  = T15
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       scandouble,
    output logic       ce_pix,
    output logic [9:0] h_cnt,
    output logic [9:0] v_cnt,
    output logic [7:0] row,
    output logic       line_start,
    output logic       frame_start,
    output logic       fetch,
    output logic       HBlank,
    output logic       HSync,
    output logic       VBlank,
    output logic       VSync
);

    // Elaboration-time sanity of the parameter set.
    if (total(H_TIM) > 12'd1024 || total(V31_TIM) > 12'd1024 || total(V15_TIM) > 12'd1024) begin : g_total_chk
        $error("vera_video_timing: timing totals must fit a 10-bit counter");
    end
    if (PIPE_DLY < 0 || PIPE_DLY > 7) begin : g_dly_chk
        $error("vera_video_timing: PIPE_DLY must be 0..7");
    end
    if (CE_DIV < 1) begin : g_div_chk
        $error("vera_video_timing: CE_DIV must be at least 1");
    end

    localparam int DIV_W = $clog2(2 * CE_DIV) + 1;
    localparam logic [DIV_W-1:0] DIV31_LAST = DIV_W'(CE_DIV - 1);
    localparam logic [DIV_W-1:0] DIV15_LAST = DIV_W'(2 * CE_DIV - 1);

    localparam logic [9:0] H_LAST   = 10'(total(H_TIM) - 12'd1);
    localparam logic [9:0] H_ACT    = H_TIM.active;
    localparam logic [9:0] HS_START = 10'({2'b00, H_TIM.active} + {2'b00, H_TIM.fp});
    localparam logic [9:0] HS_END   = 10'(sync_end(H_TIM));

    localparam logic [9:0] V31_LAST  = 10'(total(V31_TIM) - 12'd1);
    localparam logic [9:0] V31_ACT   = V31_TIM.active;
    localparam logic [9:0] V31_START = 10'({2'b00, V31_TIM.active} + {2'b00, V31_TIM.fp});
    localparam logic [9:0] V31_END   = 10'(sync_end(V31_TIM));

    localparam logic [9:0] V15_LAST  = 10'(total(V15_TIM) - 12'd1);
    localparam logic [9:0] V15_ACT   = V15_TIM.active;
    localparam logic [9:0] V15_START = 10'({2'b00, V15_TIM.active} + {2'b00, V15_TIM.fp});
    localparam logic [9:0] V15_END   = 10'(sync_end(V15_TIM));

    logic [DIV_W-1:0] div_q, div_d;
    logic             mode_q, mode_d;
    logic             ce_pix_q, ce_pix_d;
    logic [9:0]       h_cnt_q, h_cnt_d;
    logic [9:0]       v_cnt_q, v_cnt_d;
    logic [7:0]       row_q, row_d;
    logic             line_start_q, line_start_d;
    logic             frame_start_q, frame_start_d;
    logic             fetch_q, fetch_d;
    logic [3:0]       dec_q, dec_d;

    logic [DIV_W-1:0] div_last_s;
    logic             tick_s;
    logic             h_wrap_s;
    logic             v_wrap_s;
    logic             frame_end_s;
    logic [9:0]       h_next_s;
    logic [9:0]       v_next_s;
    logic [9:0]       v_act_s;
    logic [9:0]       vs_start_s;
    logic [9:0]       vs_end_s;
    logic [3:0]       dly_s;

    // Pixel divider and raster position bookkeeping for the current clk.
    always_comb begin
        div_last_s  = mode_q ? DIV31_LAST : DIV15_LAST;
        tick_s      = (div_q == div_last_s);
        h_wrap_s    = (h_cnt_q == H_LAST);
        v_wrap_s    = (v_cnt_q == (mode_q ? V31_LAST : V15_LAST));
        frame_end_s = tick_s & h_wrap_s & v_wrap_s;
        // Mode only changes as the last pixel of a frame retires, so a frame never mixes timings.
        mode_d      = frame_end_s ? scandouble : mode_q;
        div_d       = tick_s ? {DIV_W{1'b0}} : (div_q + DIV_W'(1));
        if (h_wrap_s) begin
            h_next_s = 10'd0;
            v_next_s = v_wrap_s ? 10'd0 : (v_cnt_q + 10'd1);
        end else begin
            h_next_s = h_cnt_q + 10'd1;
            v_next_s = v_cnt_q;
        end
        // Vertical decode follows the mode the new position belongs to.
        v_act_s    = mode_d ? V31_ACT   : V15_ACT;
        vs_start_s = mode_d ? V31_START : V15_START;
        vs_end_s   = mode_d ? V31_END   : V15_END;
    end

    // Next values of all registered outputs; everything moves only on a pixel tick.
    always_comb begin
        ce_pix_d      = tick_s;
        h_cnt_d       = h_cnt_q;
        v_cnt_d       = v_cnt_q;
        row_d         = row_q;
        line_start_d  = 1'b0;
        frame_start_d = 1'b0;
        fetch_d       = fetch_q;
        dec_d         = dec_q;
        if (tick_s) begin
            h_cnt_d       = h_next_s;
            v_cnt_d       = v_next_s;
            row_d         = mode_d ? v_next_s[8:1] : v_next_s[7:0];
            line_start_d  = (h_next_s == 10'd0);
            frame_start_d = (h_next_s == 10'd0) && (v_next_s == 10'd0);
            fetch_d       = (h_next_s < H_ACT) && (v_next_s < v_act_s);
            dec_d         = {(h_next_s >= H_ACT),
                             (h_next_s >= HS_START) && (h_next_s < HS_END),
                             (v_next_s >= v_act_s),
                             (v_next_s >= vs_start_s) && (v_next_s < vs_end_s)};
        end else begin
            h_cnt_d = h_cnt_q;
        end
    end

    // Timing state registers with synchronous reset; mode is captured while in reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            div_q         <= {DIV_W{1'b0}};
            mode_q        <= scandouble;
            ce_pix_q      <= 1'b0;
            h_cnt_q       <= 10'd0;
            v_cnt_q       <= 10'd0;
            row_q         <= 8'd0;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
            fetch_q       <= 1'b0;
            dec_q         <= SB_IDLE;
        end else begin
            div_q         <= div_d;
            mode_q        <= mode_d;
            ce_pix_q      <= ce_pix_d;
            h_cnt_q       <= h_cnt_d;
            v_cnt_q       <= v_cnt_d;
            row_q         <= row_d;
            line_start_q  <= line_start_d;
            frame_start_q <= frame_start_d;
            fetch_q       <= fetch_d;
            dec_q         <= dec_d;
        end
    end

    // Composer-latency alignment of sync/blank; depth 0 uses the decode directly.
    if (PIPE_DLY > 0) begin : g_dly
        vera_sync_delay #(
            .WIDTH   (4),
            .DEPTH   (PIPE_DLY),
            .RST_VAL (SB_IDLE)
        ) u_sync_delay (
            .clk   (clk),
            .reset (reset),
            .en    (tick_s),
            .din   (dec_q),
            .dout  (dly_s)
        );
    end else begin : g_nodly
        assign dly_s = dec_q;
    end

    assign ce_pix      = ce_pix_q;
    assign h_cnt       = h_cnt_q;
    assign v_cnt       = v_cnt_q;
    assign row         = row_q;
    assign line_start  = line_start_q;
    assign frame_start = frame_start_q;
    assign fetch       = fetch_q;
    assign HBlank      = dly_s[3];
    assign HSync       = dly_s[2];
    assign VBlank      = dly_s[1];
    assign VSync       = dly_s[0];

endmodule

// File: tb/tb_vera_video_timing.sv
// Scoreboard bench for vera_video_timing: two instances (no delay / 3-tick delay)
// on a reduced raster so whole frames and mode switches fit in a short run.
module tb_vera_video_timing;
    import vera_video_pkg::*;

    localparam int CE_DIV = 2;
    localparam int HA = 20, HF = 2, HS = 3, HBP = 3, HT = 28;
    localparam int VA31 = 12, VF31 = 2, VS31 = 2, VT31 = 18;
    localparam int VA15 = 6,  VF15 = 1, VS15 = 2, VT15 = 10;
    localparam timing_t TB_H   = '{active: 10'd20, fp: 10'd2, sync: 10'd3, bp: 10'd3};
    localparam timing_t TB_V31 = '{active: 10'd12, fp: 10'd2, sync: 10'd2, bp: 10'd2};
    localparam timing_t TB_V15 = '{active: 10'd6,  fp: 10'd1, sync: 10'd2, bp: 10'd1};

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic scandouble = 1'b1;
    always #5 clk = ~clk;

    logic       ce0, ls0, fs0, fe0, hb0, hs0, vb0, vs0;
    logic [9:0] h0, v0;
    logic [7:0] row0;
    logic       ce3, ls3, fs3, fe3, hb3, hs3, vb3, vs3;
    logic [9:0] h3, v3;
    logic [7:0] row3;

    vera_video_timing #(.CE_DIV(CE_DIV), .PIPE_DLY(0), .H_TIM(TB_H), .V31_TIM(TB_V31), .V15_TIM(TB_V15)) dut0 (
        .clk(clk), .reset(reset), .scandouble(scandouble), .ce_pix(ce0), .h_cnt(h0), .v_cnt(v0),
        .row(row0), .line_start(ls0), .frame_start(fs0), .fetch(fe0),
        .HBlank(hb0), .HSync(hs0), .VBlank(vb0), .VSync(vs0));

    vera_video_timing #(.CE_DIV(CE_DIV), .PIPE_DLY(3), .H_TIM(TB_H), .V31_TIM(TB_V31), .V15_TIM(TB_V15)) dut3 (
        .clk(clk), .reset(reset), .scandouble(scandouble), .ce_pix(ce3), .h_cnt(h3), .v_cnt(v3),
        .row(row3), .line_start(ls3), .frame_start(fs3), .fetch(fe3),
        .HBlank(hb3), .HSync(hs3), .VBlank(vb3), .VSync(vs3));

    int total = 0;
    int bad = 0;

    task automatic finish_test();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    endtask

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h at %0t", tag, got, exp, $time);
            if (bad >= 40) finish_test();
        end
    endtask

    // Reference model state (post-edge view).
    int         m_div, m_h, m_v, m_row;
    logic       m_mode, m_ce, m_line, m_frame, m_fetch;
    logic [3:0] m_dec;
    logic [3:0] m_hist [8];

    function automatic logic [3:0] model_dec(input int h, input int v, input logic mode);
        int va, vf, vsy;
        va  = mode ? VA31 : VA15;
        vf  = mode ? VF31 : VF15;
        vsy = mode ? VS31 : VS15;
        return {h >= HA, (h >= HA + HF) && (h < HA + HF + HS), v >= va, (v >= va + vf) && (v < va + vf + vsy)};
    endfunction

    task automatic model_step(input logic r, input logic sd);
        int dl;
        if (r) begin
            m_div = 0; m_h = 0; m_v = 0; m_row = 0; m_mode = sd;
            m_ce = 1'b0; m_line = 1'b0; m_frame = 1'b0; m_fetch = 1'b0; m_dec = 4'b1010;
            for (int i = 0; i < 8; i++) m_hist[i] = 4'b1010;
        end else begin
            dl = m_mode ? CE_DIV - 1 : 2 * CE_DIV - 1;
            if (m_div == dl) begin
                m_ce = 1'b1;
                m_div = 0;
                for (int i = 7; i > 0; i--) m_hist[i] = m_hist[i-1];
                m_hist[0] = m_dec;
                m_h++;
                if (m_h == HT) begin
                    m_h = 0;
                    m_v++;
                    if (m_v == (m_mode ? VT31 : VT15)) begin
                        m_v = 0;
                        m_mode = sd;
                    end
                end
                m_dec   = model_dec(m_h, m_v, m_mode);
                m_line  = (m_h == 0);
                m_frame = (m_h == 0) && (m_v == 0);
                m_fetch = (m_h < HA) && (m_v < (m_mode ? VA31 : VA15));
                m_row   = m_mode ? (m_v / 2) : (m_v % 256);
            end else begin
                m_div++;
                m_ce = 1'b0; m_line = 1'b0; m_frame = 1'b0;
            end
        end
    endtask

    function automatic logic [35:0] exp_vec(input int d);
        logic [3:0] sb;
        sb = (d == 0) ? m_dec : m_hist[d-1];
        return {m_ce, 10'(m_h), 10'(m_v), 8'(m_row), m_line, m_frame, m_fetch, sb};
    endfunction

    logic [35:0] q0 [$];
    logic [35:0] q3 [$];
    logic [35:0] e0, e3;

    // Scoreboard: predict at each active edge, compare on the following falling edge.
    initial begin : scoreboard
        forever begin
            @(posedge clk);
            model_step(reset, scandouble);
            q0.push_back(exp_vec(0));
            q3.push_back(exp_vec(3));
            @(negedge clk);
            e0 = q0.pop_front();
            e3 = q3.pop_front();
            check_eq("out_dly0", {ce0, h0, v0, row0, ls0, fs0, fe0, hb0, hs0, vb0, vs0}, {28'd0, e0});
            check_eq("out_dly3", {ce3, h3, v3, row3, ls3, fs3, fe3, hb3, hs3, vb3, vs3}, {28'd0, e3});
        end
    end

    task automatic clks(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Wait for the ce that puts dut0 at (h,v); bounded.
    task automatic wait_pos(input int h, input int v, input string tag);
        int n;
        n = 0;
        while (!(ce0 && h0 == 10'(h) && v0 == 10'(v)) && n < 5000) begin
            @(posedge clk); #1; n++;
        end
        check_eq(tag, 64'(n < 5000), 64'd1);
    endtask

    // Clocks from now until the next ce_pix of dut0; bounded.
    task automatic ce_gap(output int n);
        n = 0;
        do begin
            @(posedge clk); #1; n++;
        end while (!ce0 && n < 20);
    endtask

    initial begin : stimulus
        int n;
        clks(4);
        check_eq("reset_hb_vb", {hb0, hs0, vb0, vs0, hb3, hs3, vb3, vs3}, 64'hAA);
        check_eq("reset_cnt", {h0, v0, row0, ce0, ls0, fs0, fe0}, 64'd0);
        reset = 1'b0;
        ce_gap(n);
        check_eq("first_ce_31k", 64'(n), 64'd2);
        ce_gap(n);
        check_eq("ce_period_31k", 64'(n), 64'd2);

        // Full frame in 31 kHz, then mid-frame switch to 15 kHz.
        wait_pos(0, 0, "reach_frame0");
        wait_pos(0, 11, "reach_v11");
        check_eq("row_31k_v11", 64'(row0), 64'd5);
        wait_pos(0, 6, "reach_v6");
        scandouble = 1'b0;
        wait_pos(0, 12, "reach_v12");
        ce_gap(n);
        check_eq("ce_hold_31k", 64'(n), 64'd2);
        wait_pos(HT - 1, VT31 - 1, "reach_last31");
        ce_gap(n);
        check_eq("wrap_gap_31k", 64'(n), 64'd2);
        check_eq("fs_after_toggle", {fs0, h0, v0}, {1'b1, 20'd0});
        ce_gap(n);
        check_eq("ce_period_15k", 64'(n), 64'd4);

        // 15 kHz frame: row == v_cnt, wrap at 9, then switch back.
        wait_pos(0, 5, "reach15_v5");
        check_eq("row_15k_v5", 64'(row0), 64'd5);
        wait_pos(0, 7, "reach15_vs");
        check_eq("vsync_15k", 64'(vs0), 64'd1);
        wait_pos(0, 0, "wrap15");
        wait_pos(0, 3, "reach15_v3");
        scandouble = 1'b1;
        wait_pos(0, 0, "wrap15_back");
        ce_gap(n);
        check_eq("ce_period_back31", 64'(n), 64'd2);

        // Delayed blanking: HBlank on the delayed instance rises 3 ce after h=HA.
        wait_pos(HA, 1, "reach_hact");
        check_eq("fetch_fall", {fe0, fe3, hb0, hb3}, 64'b0010);
        n = 0;
        while (!hb3 && n < 10) begin
            ce_gap(n);
            n = n;
            if (hb3) begin
                check_eq("hb3_at_h", 64'(h3), 64'(HA + 3));
            end else begin
                check_eq("hb3_low_before", 64'(h3 < 10'(HA + 3)), 64'd1);
            end
            n = 0;
            if (h3 >= 10'(HA + 4)) n = 10;
        end
        check_eq("hb3_rose", 64'(hb3), 64'd1);

        // Reset in the middle of VSync.
        wait_pos(HA + 5, VA31 + VF31, "reach_vsync");
        check_eq("vs_before_reset", {vs0, vs3}, 64'b11);
        reset = 1'b1;
        clks(1);
        check_eq("reset_mid_vs", {vs0, vs3, hb0, vb0, hb3, vb3, h0, v0}, {6'b001111, 20'd0});
        reset = 1'b0;
        wait_pos(0, 0, "resume_frame");
        clks(300);

        // Reset straight into 15 kHz mode.
        scandouble = 1'b0;
        reset = 1'b1;
        clks(2);
        reset = 1'b0;
        ce_gap(n);
        check_eq("first_ce_15k", 64'(n), 64'd4);
        wait_pos(0, 0, "frame15_b");
        clks(100);
        finish_test();
    end

    // Hard bound on run time.
    initial begin : watchdog
        #400000;
        bad++;
        $display("FAIL watchdog got=timeout want=finish");
        finish_test();
    end

endmodule

// File: doc/vera_video_timing.md
Name: vera_video_timing

Overview:
- Raster timing generator for the VERA demo video path. Sits directly upstream of the pixel/composer logic inside the demo core.
- Produces the pixel clock enable, counters and fetch strobes that drive the composer.
- Produces HSync/HBlank/VSync/VBlank delayed to line up with the composer's RGB output. These signals feed the framework video outputs.
- Supports 31 kHz VGA 640x480 and 15 kHz 640x240, selected by scandouble.

Parameters:
- CE_DIV, 2: clk cycles per pixel in 31 kHz mode (15 kHz mode uses 2*CE_DIV).
- PIPE_DLY, 3: composer latency in ce_pix ticks. Applied to sync/blank outputs; range 0..7.
- H_ACTIVE, 640; H_FP, 16; H_SYNC, 96; H_BP, 48: horizontal timing in pixels (total 800).
- V31_ACTIVE, 480; V31_FP, 10; V31_SYNC, 2; V31_BP, 33: 31 kHz vertical timing (total 525).
- V15_ACTIVE, 240; V15_FP, 4; V15_SYNC, 3; V15_BP, 15: 15 kHz vertical timing (total 262).

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high.
- scandouble  in  1  1 = 31 kHz, 0 = 15 kHz. Sampled only at frame boundary.
- ce_pix  out  1  pixel enable, one clk wide.
- h_cnt  out  10  undelayed horizontal counter, 0..799.
- v_cnt  out  10  undelayed vertical counter, 0..524 or 0..261.
- row  out  8  native source row 0..239: v_cnt>>1 in 31 kHz mode, v_cnt in 15 kHz mode. Valid in active lines.
- line_start  out  1  1-ce pulse at h_cnt==0 (undelayed).
- frame_start  out  1  1-ce pulse at h_cnt==0 && v_cnt==0 (undelayed).
- fetch  out  1  high while h_cnt<H_ACTIVE and the line is active (undelayed). Composer request window.
- HBlank, HSync, VBlank, VSync  out  1 each  active-high, delayed PIPE_DLY ce ticks.

Behaviour:
- Reset values:
  - ce divider = 0; h_cnt = v_cnt = 0; row = 0.
  - line_start, frame_start, fetch = 0.
  - HBlank = VBlank = 1; HSync = VSync = 0.
  - Delay line filled with the blank/no-sync pattern.
  - Mode register = scandouble sampled during reset.
- ce_pix:
  - Divider counts 0..div-1, where div = CE_DIV (31 kHz) or 2*CE_DIV (15 kHz). ce_pix=1 when the divider == div-1.
  - First ce_pix occurs div cycles after reset release.
- Counters advance only on ce_pix.
  - h_cnt wraps 799→0.
  - On wrap, v_cnt increments and wraps at V_TOTAL-1 → 0.
- Mode latch:
  - The mode register updates from scandouble only on the ce_pix where h_cnt==799 and v_cnt==V_TOTAL-1.
  - A mid-frame toggle has no effect until that point.
- Decode, with the undelayed HS/VS/blank registered on the same ce:
  - hblank = h_cnt >= H_ACTIVE.
  - hsync = H_ACTIVE+H_FP <= h_cnt < H_ACTIVE+H_FP+H_SYNC.
  - vblank = v_cnt >= V_ACTIVE.
  - vsync = V_ACTIVE+V_FP <= v_cnt < V_ACTIVE+V_FP+V_SYNC.
- Delay line:
  - 4-bit {HB,HS,VB,VS} shift register, shifted on ce_pix only. Outputs tap stage PIPE_DLY.
  - PIPE_DLY=0: outputs equal the registered decode.
- Pulses (line_start, frame_start) are high for exactly one clk, coincident with ce_pix.
- fetch is a level signal, updated on ce_pix.
- Width rules: all compares are unsigned 10-bit; the parameter sums must fit 10 bits (checked by elaboration assertion).
- Reset mid-frame returns everything to reset values on the next clk, with no partial sync pulse extension.

Decomposition:
- Package vera_video_pkg holds:
  - the timing_t struct {active, fp, sync, bp};
  - localparams T31/T15 and H_TOTAL;
  - function total(timing_t).
- Sub-module vera_sync_delay: parameterised width/depth shift register with enable, reset fill value as a parameter. Reusable for composer alignment.

Test Plan:
- Reset release with scandouble=1 → first ce_pix at clk 2; then ce_pix every 2 clks; line period 1600 clks; frame period 840000 clks.
- 31 kHz mode, PIPE_DLY=0 → HSync high for h_cnt 656..751; VSync high for lines 490..491; VBlank low for lines 0..479; row==v_cnt>>1 (line 479 → row 239).
- scandouble=0 from reset → ce_pix every 4 clks; v_cnt wraps at 261; VSync on lines 244..246; row==v_cnt.
- Toggle scandouble at v_cnt=100 → timing unchanged until the frame end. The first frame_start after the toggle uses the new divider; no ce glitch, no short line.
- PIPE_DLY=3 → HBlank rises exactly 3 ce_pix after h_cnt reaches 640; fetch falls at h_cnt=640 undelayed.
- Assert reset at h_cnt=700, v_cnt=491 (mid-VSync) → next clk VSync=0, HBlank=VBlank=1, counters 0; normal timing resumes.
